// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor front-end: debounce FSM states and
// the default debounce window.
package sensor_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        STABLE_INACT,
        WAIT_ACT,
        STABLE_ACT,
        WAIT_INACT
    } deb_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-FF synchroniser for an active-low pin, 4-state debounce
// FSM with hold counter, and a rising-edge flag aligned with the debounced level.
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;

    // Sync flops come out of reset at 1 so an idle (high) pin never looks active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], raw_n};
        end
    end

    assign s = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_INACT;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            case (state_q)
                STABLE_INACT: begin
                    if (!s) begin
                        state_q <= WAIT_ACT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_ACT: begin
                    if (s) begin
                        state_q <= STABLE_INACT;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_ACT;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE_ACT: begin
                    if (s) begin
                        state_q <= WAIT_INACT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_INACT: begin
                    if (!s) begin
                        state_q <= STABLE_ACT;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_INACT;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_INACT;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front-end top: three debounced channels (IR, gas, flame) with registered
// outputs. Define SENSOR_ALARM_LATCH_EN to latch gas/fire alarms until alarm_clr.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ir_raw,
    input  logic gas_raw,
    input  logic fire_raw,
    input  logic alarm_clr,
    output logic obj_present,
    output logic obj_pulse,
    output logic gas_alarm,
    output logic fire_alarm,
    output logic any_alarm
);

    logic ir_level,  ir_rise;
    logic gas_level, gas_rise;
    logic fire_level, fire_rise;

    logic obj_present_q, obj_pulse_q;
    logic gas_alarm_q, gas_alarm_d;
    logic fire_alarm_q, fire_alarm_d;
    logic any_alarm_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ir (
        .clk(clk), .reset_n(reset_n), .raw_n(ir_raw), .level(ir_level), .rise(ir_rise)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gas (
        .clk(clk), .reset_n(reset_n), .raw_n(gas_raw), .level(gas_level), .rise(gas_rise)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
        .clk(clk), .reset_n(reset_n), .raw_n(fire_raw), .level(fire_level), .rise(fire_rise)
    );

`ifdef SENSOR_ALARM_LATCH_EN
    // Set on the debounced rise; clear only once the level has dropped. Set wins.
    always_comb begin
        gas_alarm_d  = gas_rise  | (gas_alarm_q  & ~(alarm_clr & ~gas_level));
        fire_alarm_d = fire_rise | (fire_alarm_q & ~(alarm_clr & ~fire_level));
    end
`else
    logic unused_default;
    assign unused_default = ^{alarm_clr, gas_rise, fire_rise};

    always_comb begin
        gas_alarm_d  = gas_level;
        fire_alarm_d = fire_level;
    end
`endif

    // any_alarm is built from the next-state alarms so it lines up with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obj_present_q <= 1'b0;
            obj_pulse_q   <= 1'b0;
            gas_alarm_q   <= 1'b0;
            fire_alarm_q  <= 1'b0;
            any_alarm_q   <= 1'b0;
        end else begin
            obj_present_q <= ir_level;
            obj_pulse_q   <= ir_rise;
            gas_alarm_q   <= gas_alarm_d;
            fire_alarm_q  <= fire_alarm_d;
            any_alarm_q   <= gas_alarm_d | fire_alarm_d;
        end
    end

    assign obj_present = obj_present_q;
    assign obj_pulse   = obj_pulse_q;
    assign gas_alarm   = gas_alarm_q;
    assign fire_alarm  = fire_alarm_q;
    assign any_alarm   = any_alarm_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=8 (11-edge latency).
// Output vector order: {obj_present, obj_pulse, gas_alarm, fire_alarm, any_alarm}.
module tb_sensor_conditioner;

    logic clk = 1'b0;
    logic reset_n;
    logic ir_raw, gas_raw, fire_raw, alarm_clr;
    logic obj_present, obj_pulse, gas_alarm, fire_alarm, any_alarm;
    logic [4:0] outs;

    int vectors = 0;
    int errs    = 0;

    sensor_conditioner #(.DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .ir_raw(ir_raw), .gas_raw(gas_raw), .fire_raw(fire_raw), .alarm_clr(alarm_clr),
        .obj_present(obj_present), .obj_pulse(obj_pulse),
        .gas_alarm(gas_alarm), .fire_alarm(fire_alarm), .any_alarm(any_alarm)
    );

    assign outs = {obj_present, obj_pulse, gas_alarm, fire_alarm, any_alarm};

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with pins driven active: outputs must stay 0.
        reset_n = 1'b0; alarm_clr = 1'b0;
        ir_raw = 1'b0; gas_raw = 1'b0; fire_raw = 1'b0;
        tick(4);
        check("reset_hold", outs, 5'b00000);
        ir_raw = 1'b1; gas_raw = 1'b1; fire_raw = 1'b1;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("post_reset_idle", outs, 5'b00000);
        end

        // Clean press: 11 edges to accept, one-cycle pulse.
        ir_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("press_latency", outs, 5'b00000);
        end
        tick(1);
        check("press_edge11", outs, 5'b11000);
        tick(1);
        check("press_pulse_end", outs, 5'b10000);
        tick(8);
        ir_raw = 1'b1;
        tick(10);
        check("release_edge10", outs, 5'b10000);
        tick(1);
        check("release_edge11", outs, 5'b00000);
        tick(5);

        // Glitch of 7 cycles is rejected.
        ir_raw = 1'b0;
        tick(7);
        ir_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("glitch7", outs, 5'b00000);
        end

        // 8 cycles low is accepted exactly 11 edges after the fall.
        ir_raw = 1'b0;
        tick(8);
        ir_raw = 1'b1;
        tick(2);
        check("low8_edge10", outs, 5'b00000);
        tick(1);
        check("low8_edge11", outs, 5'b11000);
        tick(15);
        check("low8_released", outs, 5'b00000);

        // Bounce gas every 3 cycles for 30 cycles, then hold low.
        for (int seg = 0; seg < 10; seg++) begin
            gas_raw = (seg % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check("bounce_no_alarm", outs, 5'b00000);
            end
        end
        gas_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("settle_latency", outs, 5'b00000);
        end
        tick(1);
        check("settle_edge11", outs, 5'b00101);
        gas_raw = 1'b1;
        tick(15);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        tick(1);
        check("gas_cleared", outs, 5'b00000);

        // All three pins fall together: identical latency, any_alarm aligned.
        ir_raw = 1'b0; gas_raw = 1'b0; fire_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("simul_latency", outs, 5'b00000);
        end
        tick(1);
        check("simul_edge11", outs, 5'b11111);
        tick(1);
        check("simul_hold", outs, 5'b10111);
        ir_raw = 1'b1; gas_raw = 1'b1; fire_raw = 1'b1;
        tick(15);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        tick(1);
        check("simul_cleared", outs, 5'b00000);

`ifdef SENSOR_ALARM_LATCH_EN
        // Fire pulse latches; clear while still active is ignored.
        fire_raw = 1'b0;
        tick(11);
        check("latch_set", outs, 5'b00011);
        tick(1);
        fire_raw = 1'b1;
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        check("clr_while_active", outs, 5'b00011);
        tick(15);
        check("latch_hold_after_release", outs, 5'b00011);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        check("clr_after_release", outs, 5'b00000);

        // Clear held across the set cycle: set wins.
        alarm_clr = 1'b1;
        fire_raw = 1'b0;
        tick(10);
        check("set_clr_before", outs, 5'b00000);
        tick(1);
        check("set_clr_same_cycle", outs, 5'b00011);
        tick(1);
        check("set_clr_hold", outs, 5'b00011);
        alarm_clr = 1'b0;
        fire_raw = 1'b1;
        tick(15);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        tick(1);
        check("set_clr_final", outs, 5'b00000);
`else
        // Without latching, fire_alarm follows the level and alarm_clr is ignored.
        fire_raw = 1'b0;
        alarm_clr = 1'b1;
        tick(11);
        check("fire_follow_set", outs, 5'b00011);
        tick(1);
        fire_raw = 1'b1;
        tick(10);
        check("fire_follow_edge10", outs, 5'b00011);
        tick(1);
        check("fire_follow_edge11", outs, 5'b00000);
        alarm_clr = 1'b0;
        tick(3);
`endif

        // Reset just before the pulse would appear: pulse discarded.
        ir_raw = 1'b0;
        tick(10);
        reset_n = 1'b0;
        ir_raw = 1'b1;
        tick(1);
        check("reset_mid_debounce", outs, 5'b00000);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("after_mid_reset", outs, 5'b00000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
